pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
//  Generates per-register stall/flush, detects load-use hazards the forwarding unit cannot cover,
//  and sequences EX branch redirects against in-flight Wishbone instruction fetches.
//  Freezes the front end during data-bus waits. Keeps saturating stall/flush performance counters.
// PARAMETERS
//  ADDR_WIDTH  32  PC / redirect target width
//  CNT_WIDTH   32  perf counter width
// PORTS
//  clk_i            in   1   pipeline clock
//  rst_ni           in   1   async active-low reset
//  if_req_i         in   1   IF Wishbone cycle outstanding
//  if_ack_i         in   1   IF Wishbone ack
//  mem_req_i        in   1   MEM-stage Wishbone cycle outstanding
//  mem_ack_i        in   1   MEM-stage Wishbone ack
//  IDEX_mem_read_i  in   1   instruction in EX is a load
//  IDEX_rd_addr_i   in   5   rd of instruction in EX
//  IFID_rs1_addr_i  in   5   rs1 of instruction in ID
//  IFID_rs2_addr_i  in   5   rs2 of instruction in ID
//  IFID_use_rs1_i   in   1   ID instruction reads rs1
//  IFID_use_rs2_i   in   1   ID instruction reads rs2
//  ex_redirect_i    in   1   EX resolved taken branch/jump
//  ex_target_i      in   AW  redirect target
//  pc_stall_o       out  1   hold PC
//  ifid_stall_o / ifid_flush_o    out 1   hold / clear-to-NOP IF/ID
//  idex_stall_o / idex_flush_o    out 1   hold / bubble ID/EX
//  exmem_stall_o    out  1   hold EX/MEM
//  memwb_flush_o    out  1   bubble MEM/WB (RegWrite=0)
//  redirect_valid_o out  1   PC loads redirect_pc_o this cycle
//  redirect_pc_o    out  AW  redirect target
//  stall_cnt_o      out  CW  cycles with pc_stall_o=1
//  flush_cnt_o      out  CW  count of redirect_valid_o pulses
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=RUN, pend_pc=0, counters=0; comb outputs then follow RUN rules (all 0 with idle inputs).
//  mem_wait = mem_req_i & ~mem_ack_i. load_use = IDEX_mem_read_i & rd!=0 &
//    ((use_rs1 & rd==rs1) | (use_rs2 & rd==rs2)). ex_adv = ~mem_wait.
//  Priority per cycle: mem_wait > redirect > load_use.
//  mem_wait: pc/ifid/idex/exmem stall=1, memwb_flush=1; ex_redirect_i ignored (EX held, re-presented).
//  State RUN:
//   - ex_adv & ex_redirect_i & (~if_req_i | if_ack_i): ifid_flush=idex_flush=1, redirect_valid=1,
//     redirect_pc=ex_target_i, same cycle (0 latency); stay RUN.
//   - ex_adv & ex_redirect_i & if_req_i & ~if_ack_i: pend_pc<=ex_target_i; ifid_flush=idex_flush=1,
//     pc_stall=1; -> REDIR_WAIT.
//   - load_use (no redirect, no mem_wait): pc_stall=ifid_stall=1, idex_flush=1 for exactly 1 cycle.
//  State REDIR_WAIT: pc_stall=1, ifid_flush=1 every cycle (wrong-path fetch discarded);
//   on if_ack_i: redirect_valid=1, redirect_pc=pend_pc -> RUN. mem_wait may overlap: both apply,
//   redirect still issues on if_ack_i. load_use ignored (ID holds flushed NOP).
//  redirect_pc_o = ex_target_i in RUN, pend_pc in REDIR_WAIT; meaningful only when redirect_valid_o.
//  Counters: registered, saturate at all-ones, never wrap; reset only by rst_ni.
//  No output is asserted while stall and flush of the same register conflict: flush wins for IF/ID, ID/EX.
// STRUCTURE
//  pipe_ctrl_pkg: typedef enum logic {RUN, REDIR_WAIT} pctrl_state_e; NOP_INSTR=32'h0000_0013.
//  Sub-module hazard_detect (combinational load_use compare); FSM, pend_pc, counters stay top-level.
// TESTING
//  lw x5 in EX, add x6,x5,x1 in ID -> 1 cycle pc_stall=ifid_stall=idex_flush=1, stall_cnt +1.
//  lw x0 in EX, ID reads x0 -> no stall.
//  redirect to 0x8000_0100 with IF idle -> same-cycle redirect_valid, redirect_pc=0x8000_0100, flush_cnt=1.
//  redirect while IF ack arrives 3 cycles later -> REDIR_WAIT 3 cycles, pc_stall=1; redirect on ack cycle.
//  mem_wait 4 cycles with ex_redirect_i high -> 4 cycles full freeze + memwb_flush, redirect on 5th.
//  rst_ni low in REDIR_WAIT -> immediate RUN, no redirect_valid, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
//   pctrl_state_e : controller state (RUN, REDIR_WAIT)
//   NOP_INSTR     : encoding of addi x0,x0,0 used when IF/ID is cleared
//   reg_match     : true when a used source register equals a destination register
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN,
    REDIR_WAIT
  } pctrl_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic reg_match(input logic use_r, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_r & (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between the pipeline datapath and pipeline_ctrl.
//   master : datapath side (drives hazard/bus status, receives stall/flush/redirect)
//   slave  : controller side
// Signals (see pipeline_ctrl header for meaning):
//   in  : if_req_i, if_ack_i, mem_req_i, mem_ack_i, IDEX_mem_read_i, IDEX_rd_addr_i,
//         IFID_rs1_addr_i, IFID_rs2_addr_i, IFID_use_rs1_i, IFID_use_rs2_i,
//         ex_redirect_i, ex_target_i
//   out : pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
//         exmem_stall_o, memwb_flush_o, redirect_valid_o, redirect_pc_o,
//         stall_cnt_o, flush_cnt_o
interface pipeline_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) ();

  logic                  if_req_i;
  logic                  if_ack_i;
  logic                  mem_req_i;
  logic                  mem_ack_i;
  logic                  IDEX_mem_read_i;
  logic [4:0]            IDEX_rd_addr_i;
  logic [4:0]            IFID_rs1_addr_i;
  logic [4:0]            IFID_rs2_addr_i;
  logic                  IFID_use_rs1_i;
  logic                  IFID_use_rs2_i;
  logic                  ex_redirect_i;
  logic [ADDR_WIDTH-1:0] ex_target_i;

  logic                  pc_stall_o;
  logic                  ifid_stall_o;
  logic                  ifid_flush_o;
  logic                  idex_stall_o;
  logic                  idex_flush_o;
  logic                  exmem_stall_o;
  logic                  memwb_flush_o;
  logic                  redirect_valid_o;
  logic [ADDR_WIDTH-1:0] redirect_pc_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic [CNT_WIDTH-1:0]  flush_cnt_o;

  modport master (
    output if_req_i, if_ack_i, mem_req_i, mem_ack_i, IDEX_mem_read_i, IDEX_rd_addr_i,
           IFID_rs1_addr_i, IFID_rs2_addr_i, IFID_use_rs1_i, IFID_use_rs2_i,
           ex_redirect_i, ex_target_i,
    input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
           exmem_stall_o, memwb_flush_o, redirect_valid_o, redirect_pc_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  if_req_i, if_ack_i, mem_req_i, mem_ack_i, IDEX_mem_read_i, IDEX_rd_addr_i,
           IFID_rs1_addr_i, IFID_rs2_addr_i, IFID_use_rs1_i, IFID_use_rs2_i,
           ex_redirect_i, ex_target_i,
    output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
           exmem_stall_o, memwb_flush_o, redirect_valid_o, redirect_pc_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose rd feeds a source that the
// ID instruction actually reads cannot be forwarded in time.
//   idex_mem_read : EX instruction is a load
//   idex_rd_addr  : rd of EX instruction
//   ifid_rs1_addr / ifid_rs2_addr : sources of ID instruction
//   ifid_use_rs1 / ifid_use_rs2   : ID instruction reads that source
//   load_use      : hazard detected
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd_addr,
  input  logic [4:0] ifid_rs1_addr,
  input  logic [4:0] ifid_rs2_addr,
  input  logic       ifid_use_rs1,
  input  logic       ifid_use_rs2,
  output logic       load_use
);

  // x0 is never written, so a load targeting it creates no dependency.
  assign load_use = idex_mem_read & (idex_rd_addr != 5'd0) &
                    (reg_match(ifid_use_rs1, ifid_rs1_addr, idex_rd_addr) |
                     reg_match(ifid_use_rs2, ifid_rs2_addr, idex_rd_addr));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline.
//   clk_i  : pipeline clock
//   rst_ni : async active-low reset
//   bus    : pipeline_ctrl_if.slave -- hazard/bus status in; per-register stall/flush,
//            redirect valid/pc and saturating stall/flush counters out.
// Data-bus waits freeze the whole front end and bubble MEM/WB. Taken EX redirects issue
// the same cycle unless an IF fetch is still in flight, in which case the target is parked
// until that fetch acks and the wrong-path instruction is discarded.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  pipeline_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  pctrl_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic load_use;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, memwb_flush, redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  assign mem_wait = bus.mem_req_i & ~bus.mem_ack_i;

  hazard_detect u_hazard_detect (
    .idex_mem_read (bus.IDEX_mem_read_i),
    .idex_rd_addr  (bus.IDEX_rd_addr_i),
    .ifid_rs1_addr (bus.IFID_rs1_addr_i),
    .ifid_rs2_addr (bus.IFID_rs2_addr_i),
    .ifid_use_rs1  (bus.IFID_use_rs1_i),
    .ifid_use_rs2  (bus.IFID_use_rs2_i),
    .load_use      (load_use)
  );

  always_comb begin
    state_d        = state_q;
    pend_pc_d      = pend_pc_q;
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idex_stall     = 1'b0;
    idex_flush     = 1'b0;
    exmem_stall    = 1'b0;
    memwb_flush    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = (state_q == REDIR_WAIT) ? pend_pc_q : bus.ex_target_i;

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          // EX is held, so a redirect there is simply re-presented once the bus is free.
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
        end else if (bus.ex_redirect_i) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (!bus.if_req_i || bus.if_ack_i) begin
            redirect_valid = 1'b1;
          end else begin
            // Fetch in flight: cannot retarget the PC until it completes.
            pc_stall  = 1'b1;
            pend_pc_d = bus.ex_target_i;
            state_d   = REDIR_WAIT;
          end
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
      REDIR_WAIT: begin
        // IF/ID is cleared every cycle, so flush takes precedence over any freeze stall.
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        if (mem_wait) begin
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
        end
        if (bus.if_ack_i) begin
          redirect_valid = 1'b1;
          state_d        = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (redirect_valid && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_stall_o       = pc_stall;
  assign bus.ifid_stall_o     = ifid_stall;
  assign bus.ifid_flush_o     = ifid_flush;
  assign bus.idex_stall_o     = idex_stall;
  assign bus.idex_flush_o     = idex_flush;
  assign bus.exmem_stall_o    = exmem_stall;
  assign bus.memwb_flush_o    = memwb_flush;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;
  assign bus.stall_cnt_o      = stall_cnt_q;
  assign bus.flush_cnt_o      = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  pipeline_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  pipeline_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: whether a redirect is parked behind a fetch, its target, event counts.
  bit          m_wait;
  logic [AW-1:0] m_pend;
  int          m_stall_cnt;
  int          m_flush_cnt;

  // Expected outputs for the current cycle.
  bit e_pc_stall, e_ifid_stall, e_ifid_flush, e_idex_stall, e_idex_flush;
  bit e_exmem_stall, e_memwb_flush, e_rv;
  logic [AW-1:0] e_rpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic model_reset();
    m_wait      = 1'b0;
    m_pend      = '0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic set_idle();
    bus.if_req_i        = 1'b0;
    bus.if_ack_i        = 1'b0;
    bus.mem_req_i       = 1'b0;
    bus.mem_ack_i       = 1'b0;
    bus.IDEX_mem_read_i = 1'b0;
    bus.IDEX_rd_addr_i  = 5'd0;
    bus.IFID_rs1_addr_i = 5'd0;
    bus.IFID_rs2_addr_i = 5'd0;
    bus.IFID_use_rs1_i  = 1'b0;
    bus.IFID_use_rs2_i  = 1'b0;
    bus.ex_redirect_i   = 1'b0;
    bus.ex_target_i     = '0;
  endtask

  // Derive the required outputs from the pipeline rules for this cycle.
  task automatic model_eval();
    bit frozen, dep;
    frozen = bus.mem_req_i && !bus.mem_ack_i;
    dep = bus.IDEX_mem_read_i && bus.IDEX_rd_addr_i != 0 &&
          ((bus.IFID_use_rs1_i && bus.IFID_rs1_addr_i == bus.IDEX_rd_addr_i) ||
           (bus.IFID_use_rs2_i && bus.IFID_rs2_addr_i == bus.IDEX_rd_addr_i));
    {e_pc_stall, e_ifid_stall, e_ifid_flush, e_idex_stall} = '0;
    {e_idex_flush, e_exmem_stall, e_memwb_flush, e_rv} = '0;
    e_rpc = 'x;
    if (m_wait) begin
      e_pc_stall   = 1;
      e_ifid_flush = 1;
      if (frozen) {e_idex_stall, e_exmem_stall, e_memwb_flush} = 3'b111;
      if (bus.if_ack_i) begin
        e_rv  = 1;
        e_rpc = m_pend;
      end
    end else if (frozen) begin
      {e_pc_stall, e_ifid_stall, e_idex_stall, e_exmem_stall, e_memwb_flush} = 5'b11111;
    end else if (bus.ex_redirect_i) begin
      e_ifid_flush = 1;
      e_idex_flush = 1;
      if (bus.if_req_i && !bus.if_ack_i) e_pc_stall = 1;
      else begin
        e_rv  = 1;
        e_rpc = bus.ex_target_i;
      end
    end else if (dep) begin
      {e_pc_stall, e_ifid_stall, e_idex_flush} = 3'b111;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("pc_stall", bus.pc_stall_o, e_pc_stall);
    chk("ifid_stall", bus.ifid_stall_o, e_ifid_stall);
    chk("ifid_flush", bus.ifid_flush_o, e_ifid_flush);
    chk("idex_stall", bus.idex_stall_o, e_idex_stall);
    chk("idex_flush", bus.idex_flush_o, e_idex_flush);
    chk("exmem_stall", bus.exmem_stall_o, e_exmem_stall);
    chk("memwb_flush", bus.memwb_flush_o, e_memwb_flush);
    chk("redirect_valid", bus.redirect_valid_o, e_rv);
    if (e_rv) chk("redirect_pc", bus.redirect_pc_o, e_rpc);
    chk("stall_cnt", bus.stall_cnt_o, m_stall_cnt);
    chk("flush_cnt", bus.flush_cnt_o, m_flush_cnt);
  endtask

  task automatic advance();
    if (!rst_ni) model_reset();
    else begin
      if (m_wait && bus.if_ack_i) m_wait = 1'b0;
      else if (!m_wait && e_ifid_flush && e_pc_stall) begin
        m_wait = 1'b1;
        m_pend = bus.ex_target_i;
      end
      if (e_pc_stall) m_stall_cnt = (m_stall_cnt >= CMAX) ? CMAX : m_stall_cnt + 1;
      if (e_rv) m_flush_cnt = (m_flush_cnt >= CMAX) ? CMAX : m_flush_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    model_reset();
    rst_ni = 1'b0;
    sample();
    chk("rst_pc_stall", bus.pc_stall_o, 0);
    chk("rst_rv", bus.redirect_valid_o, 0);
    chk("rst_stall_cnt", bus.stall_cnt_o, 0);
    advance();
    rst_ni = 1'b1;

    // lw x5 in EX, add x6,x5,x1 in ID
    bus.IDEX_mem_read_i = 1; bus.IDEX_rd_addr_i = 5'd5;
    bus.IFID_rs1_addr_i = 5'd5; bus.IFID_use_rs1_i = 1;
    bus.IFID_rs2_addr_i = 5'd1; bus.IFID_use_rs2_i = 1;
    sample();
    chk("lu_pc_stall", bus.pc_stall_o, 1);
    chk("lu_ifid_stall", bus.ifid_stall_o, 1);
    chk("lu_idex_flush", bus.idex_flush_o, 1);
    advance();
    set_idle();
    sample();
    chk("lu_once", bus.pc_stall_o, 0);
    chk("lu_stall_cnt", bus.stall_cnt_o, 1);
    advance();

    // lw x0 with ID reading x0
    bus.IDEX_mem_read_i = 1; bus.IDEX_rd_addr_i = 5'd0;
    bus.IFID_use_rs1_i = 1; bus.IFID_use_rs2_i = 1;
    sample();
    chk("x0_pc_stall", bus.pc_stall_o, 0);
    chk("x0_idex_flush", bus.idex_flush_o, 0);
    advance();

    // Redirect with IF idle: same-cycle
    set_idle();
    bus.ex_redirect_i = 1; bus.ex_target_i = 32'h8000_0100;
    sample();
    chk("rd0_valid", bus.redirect_valid_o, 1);
    chk("rd0_pc", bus.redirect_pc_o, 64'h8000_0100);
    chk("rd0_pc_stall", bus.pc_stall_o, 0);
    advance();
    set_idle();
    sample();
    chk("rd0_flush_cnt", bus.flush_cnt_o, 1);
    advance();

    // Redirect behind an in-flight fetch that acks 3 cycles later
    bus.ex_redirect_i = 1; bus.ex_target_i = 32'h8000_0200; bus.if_req_i = 1;
    sample();
    chk("rw_enter_stall", bus.pc_stall_o, 1);
    chk("rw_enter_rv", bus.redirect_valid_o, 0);
    advance();
    set_idle();
    bus.if_req_i = 1;
    bus.ex_target_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      bus.if_ack_i = (i == 2);
      sample();
      chk("rw_pc_stall", bus.pc_stall_o, 1);
      chk("rw_rv", bus.redirect_valid_o, (i == 2));
      if (i == 2) chk("rw_pc", bus.redirect_pc_o, 64'h8000_0200);
      advance();
    end
    set_idle();
    sample();
    chk("rw_flush_cnt", bus.flush_cnt_o, 2);
    chk("rw_stall_cnt", bus.stall_cnt_o, 5);
    advance();

    // Data-bus wait for 4 cycles with a redirect held in EX
    bus.ex_redirect_i = 1; bus.ex_target_i = 32'h8000_0300; bus.mem_req_i = 1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack_i = (i == 4);
      sample();
      chk("mw_rv", bus.redirect_valid_o, (i == 4));
      chk("mw_memwb_flush", bus.memwb_flush_o, (i < 4));
      chk("mw_exmem_stall", bus.exmem_stall_o, (i < 4));
      if (i == 4) chk("mw_pc", bus.redirect_pc_o, 64'h8000_0300);
      advance();
    end
    set_idle();
    sample();
    chk("mw_stall_cnt", bus.stall_cnt_o, 9);
    chk("mw_flush_cnt", bus.flush_cnt_o, 3);
    advance();

    // Reset while waiting on a fetch
    bus.ex_redirect_i = 1; bus.ex_target_i = 32'h8000_0400; bus.if_req_i = 1;
    sample();
    advance();
    set_idle();
    bus.if_req_i = 1;
    rst_ni = 1'b0;
    #1;
    model_reset();
    bus.if_ack_i = 1;
    sample();
    chk("rstw_rv", bus.redirect_valid_o, 0);
    chk("rstw_pc_stall", bus.pc_stall_o, 0);
    chk("rstw_stall_cnt", bus.stall_cnt_o, 0);
    chk("rstw_flush_cnt", bus.flush_cnt_o, 0);
    advance();
    rst_ni = 1'b1;
    sample();
    chk("rstw_run", bus.ifid_flush_o, 0);
    advance();

    // Long freeze drives the stall counter into saturation
    set_idle();
    bus.mem_req_i = 1;
    for (int i = 0; i < 20; i++) begin
      sample();
      advance();
    end
    set_idle();
    sample();
    chk("sat_stall_cnt", bus.stall_cnt_o, 15);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.if_req_i        = ($urandom_range(0, 1) == 1);
      bus.if_ack_i        = ($urandom_range(0, 9) < 4);
      bus.mem_req_i       = ($urandom_range(0, 9) < 3);
      bus.mem_ack_i       = ($urandom_range(0, 1) == 1);
      bus.IDEX_mem_read_i = ($urandom_range(0, 9) < 4);
      bus.IDEX_rd_addr_i  = 5'($urandom_range(0, 3));
      bus.IFID_rs1_addr_i = 5'($urandom_range(0, 3));
      bus.IFID_rs2_addr_i = 5'($urandom_range(0, 3));
      bus.IFID_use_rs1_i  = ($urandom_range(0, 1) == 1);
      bus.IFID_use_rs2_i  = ($urandom_range(0, 1) == 1);
      bus.ex_redirect_i   = ($urandom_range(0, 9) < 2);
      bus.ex_target_i     = $urandom;
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
